// File: rtl/vend_pkg.sv
// Shared coin values, coin selector type and change-dispenser state encoding.
package vend_pkg;

  localparam logic [7:0] NICKEL_C  = 8'd5;
  localparam logic [7:0] DIME_C    = 8'd10;
  localparam logic [7:0] QUARTER_C = 8'd25;

  typedef enum logic [1:0] {NONE, N, D, Q} coin_t;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StRequest,
    StGap,
    StDone,
    StFault
  } disp_state_t;

endpackage

// File: rtl/change_coin_select.sv
// Greedy coin choice: the largest coin that does not exceed the remaining credit.
module change_coin_select
  import vend_pkg::*;
(
  input  logic [7:0] rem,
  output coin_t      coin,
  output logic [7:0] value
);

  always_comb begin
    coin  = NONE;
    value = 8'd0;
    if (rem >= QUARTER_C) begin
      coin  = Q;
      value = QUARTER_C;
    end else if (rem >= DIME_C) begin
      coin  = D;
      value = DIME_C;
    end else if (rem >= NICKEL_C) begin
      coin  = N;
      value = NICKEL_C;
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out credit one coin at a time over a request/acknowledge handshake to
// a coin ejector, with inter-coin gap, coin counting and ejector-stall fault.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int unsigned GAP_CYCLES  = 4,
  parameter int unsigned ACK_TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] credit,
  input  logic       mech_ack,
  output logic       eject_quarter,
  output logic       eject_dime,
  output logic       eject_nickel,
  output logic       busy,
  output logic       done,
  output logic [5:0] coin_count,
  output logic [2:0] residue,
  output logic       fault
);

  localparam int unsigned TmrW = $clog2(ACK_TIMEOUT + 1);
  localparam int unsigned GapW = (GAP_CYCLES == 0) ? 1 : $clog2(GAP_CYCLES + 1);
  localparam logic [TmrW-1:0] TmrLoad = TmrW'(ACK_TIMEOUT);
  localparam logic [GapW-1:0] GapLoad = GapW'(GAP_CYCLES);

  disp_state_t     state_q, state_d;
  logic [7:0]      rem_q, rem_d;
  logic [TmrW-1:0] tmr_q, tmr_d;
  logic [GapW-1:0] gap_q, gap_d;
  // {quarter, dime, nickel}
  logic [2:0]      eject_q, eject_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [5:0]      count_q, count_d;
  logic [2:0]      residue_q, residue_d;
  logic            fault_q, fault_d;

  coin_t      sel_coin;
  logic [7:0] sel_value;

  change_coin_select u_select (
    .rem   (rem_q),
    .coin  (sel_coin),
    .value (sel_value)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      rem_q     <= 8'd0;
      tmr_q     <= '0;
      gap_q     <= '0;
      eject_q   <= 3'b000;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= 6'd0;
      residue_q <= 3'd0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      tmr_q     <= tmr_d;
      gap_q     <= gap_d;
      eject_q   <= eject_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      count_q   <= count_d;
      residue_q <= residue_d;
      fault_q   <= fault_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    tmr_d     = tmr_q;
    gap_d     = gap_q;
    eject_d   = eject_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    count_d   = count_q;
    residue_d = residue_q;
    fault_d   = fault_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          rem_d     = credit;
          count_d   = 6'd0;
          residue_d = 3'd0;
          busy_d    = 1'b1;
          state_d   = StSelect;
        end
      end
      StSelect: begin
        if (sel_coin == NONE) begin
          residue_d = rem_q[2:0];
          state_d   = StDone;
        end else begin
          unique case (sel_coin)
            Q:       eject_d = 3'b100;
            D:       eject_d = 3'b010;
            default: eject_d = 3'b001;
          endcase
          tmr_d   = TmrLoad;
          state_d = StRequest;
        end
      end
      StRequest: begin
        // rem is stable while requesting, so the selector still names the pending coin
        if (mech_ack) begin
          eject_d = 3'b000;
          rem_d   = rem_q - sel_value;
          count_d = count_q + 6'd1;
          if (GAP_CYCLES == 0) begin
            state_d = StSelect;
          end else begin
            gap_d   = GapLoad;
            state_d = StGap;
          end
        end else if (tmr_q <= TmrW'(1)) begin
          tmr_d   = '0;
          eject_d = 3'b000;
          fault_d = 1'b1;
          state_d = StFault;
        end else begin
          tmr_d = tmr_q - TmrW'(1);
        end
      end
      StGap: begin
        if (gap_q <= GapW'(1)) begin
          gap_d   = '0;
          state_d = StSelect;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      StDone: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      StFault: begin
        eject_d = 3'b000;
        fault_d = 1'b1;
        busy_d  = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign eject_quarter = eject_q[2];
  assign eject_dime    = eject_q[1];
  assign eject_nickel  = eject_q[0];
  assign busy          = busy_q;
  assign done          = done_q;
  assign coin_count    = count_q;
  assign residue       = residue_q;
  assign fault         = fault_q;

endmodule
